// File: rtl/noc_pkg.sv
// Shared constants and types for the 16-port NoC fabric and its output schedulers.
package noc_pkg;

  localparam int N_PORTS  = 16;
  localparam int DW       = 8;
  localparam int DEST_MSB = 7;
  localparam int DEST_LSB = 4;
  localparam int DEST_W   = DEST_MSB - DEST_LSB + 1;

  typedef logic [DW-1:0] flit_t;
  typedef logic [3:0]    port_idx_t;

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after rr_ptr, wrapping modulo N.
module noc_rr_pick
  import noc_pkg::*;
#(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  logic [IW:0]   sum_next;
  logic [IW-1:0] idx_next;

  // Scan from the far end back toward rr_ptr so the nearest request is assigned last and wins.
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = '0;
    sum_next  = '0;
    idx_next  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      sum_next = {1'b0, rr_ptr} + (IW+1)'(k);
      if (sum_next >= (IW+1)'(N)) begin
        sum_next = sum_next - (IW+1)'(N);
      end
      idx_next = sum_next[IW-1:0];
      if (req[idx_next]) begin
        gnt_idx = idx_next;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-output scheduler: one pending slot per input, round-robin grant into a registered output stage.
// Optional drop counter enabled by defining NOC_ARB_DROP_CNT_EN.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int N_PORTS = 16,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_PORTS-1:0]    wr,
  input  logic [N_PORTS*DW-1:0] data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         datao,
  output port_idx_t             out_src,
  output logic [N_PORTS-1:0]    pend,
  output logic [15:0]           drop_cnt
);

  localparam int IW = $clog2(N_PORTS);

  logic                  out_valid_reg;
  logic [DW-1:0]         datao_reg;
  port_idx_t             out_src_reg;
  logic [IW-1:0]         rr_ptr_reg;
  logic [N_PORTS-1:0]    pend_vec;
  logic [N_PORTS*DW-1:0] slot_flat;
  logic                  out_free;
  logic                  gnt_valid;
  logic [IW-1:0]         gnt_idx;
  logic                  grant;
`ifdef NOC_ARB_DROP_CNT_EN
  logic [N_PORTS-1:0]    drop;
`endif

  assign out_free = !out_valid_reg || out_ready;
  assign grant    = out_free && gnt_valid;

  noc_rr_pick #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_pick (
    .req       (pend_vec),
    .rr_ptr    (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_slot
      logic          pend_reg;
      logic [DW-1:0] slot_reg;
      logic          dest_hit;
      logic          granted;
      logic          slot_free;

      assign dest_hit  = wr[gi] && (data[gi*DW+DEST_LSB +: DEST_W] == DEST_W'(PORT_ID));
      assign granted   = grant && (gnt_idx == IW'(gi));
      // A slot being granted this edge can accept a new flit at the same edge.
      assign slot_free = !pend_reg || granted;
`ifdef NOC_ARB_DROP_CNT_EN
      assign drop[gi]  = dest_hit && !slot_free;
`endif

      always_ff @(posedge clk) begin
        if (reset) begin
          pend_reg <= 1'b0;
          slot_reg <= '0;
        end else if (dest_hit && slot_free) begin
          pend_reg <= 1'b1;
          slot_reg <= data[gi*DW +: DW];
        end else if (granted) begin
          pend_reg <= 1'b0;
        end
      end

      assign pend_vec[gi]            = pend_reg;
      assign slot_flat[gi*DW +: DW] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      datao_reg     <= '0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (grant) begin
      out_valid_reg <= 1'b1;
      datao_reg     <= slot_flat[gnt_idx*DW +: DW];
      out_src_reg   <= port_idx_t'(gnt_idx);
      rr_ptr_reg    <= (gnt_idx == IW'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (out_free) begin
      out_valid_reg <= 1'b0;
    end
  end

`ifdef NOC_ARB_DROP_CNT_EN
  logic [16:0] drop_sum_next;
  logic [15:0] drop_cnt_reg;

  always_comb begin
    drop_sum_next = {1'b0, drop_cnt_reg};
    for (int k = 0; k < N_PORTS; k++) begin
      drop_sum_next = drop_sum_next + 17'(drop[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt_reg <= '0;
    end else if (drop_sum_next[16]) begin
      drop_cnt_reg <= 16'hFFFF;
    end else begin
      drop_cnt_reg <= drop_sum_next[15:0];
    end
  end

  assign drop_cnt = drop_cnt_reg;
`else
  assign drop_cnt = '0;
`endif

  assign out_valid = out_valid_reg;
  assign datao     = datao_reg;
  assign out_src   = out_src_reg;
  assign pend      = pend_vec;

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed bench for noc_out_arbiter with PORT_ID=1; drop expectations follow NOC_ARB_DROP_CNT_EN.
module tb_noc_out_arbiter;

  localparam int NP = 16;
  localparam int W  = 8;
`ifdef NOC_ARB_DROP_CNT_EN
  localparam int DROP_EXP = 1;
`else
  localparam int DROP_EXP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [NP-1:0] wr;
  logic [NP*W-1:0] data;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  datao;
  logic [3:0]    out_src;
  logic [NP-1:0] pend;
  logic [15:0]   drop_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  noc_out_arbiter #(
    .PORT_ID (1),
    .N_PORTS (NP),
    .DW      (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr        (wr),
    .data      (data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .datao     (datao),
    .out_src   (out_src),
    .pend      (pend),
    .drop_cnt  (drop_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int idx, input logic [7:0] flit);
    wr[idx] = 1'b1;
    data[idx*W +: W] = flit;
  endtask

  task automatic idle();
    wr   = '0;
    data = '0;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_datao", 32'(datao), 32'h0);
    check("rst_src", 32'(out_src), 32'h0);
    check("rst_pend", 32'(pend), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);

    // single flit: visible one cycle after capture
    put(0, 8'h17);
    tick();
    idle();
    check("single_pend", 32'(pend), 32'h0001);
    check("single_valid_early", 32'(out_valid), 32'h0);
    tick();
    check("single_valid", 32'(out_valid), 32'h1);
    check("single_datao", 32'(datao), 32'h17);
    check("single_src", 32'(out_src), 32'h0);
    check("single_pend_clr", 32'(pend), 32'h0);
    tick();
    check("single_drain", 32'(out_valid), 32'h0);

    // destination filter
    put(4, 8'h32);
    tick();
    idle();
    check("filter_pend", 32'(pend), 32'h0);
    tick();
    check("filter_valid", 32'(out_valid), 32'h0);
    check("filter_drop", 32'(drop_cnt), 32'h0);

    // round robin, pointer at 1
    put(2, 8'h12);
    put(5, 8'h15);
    put(9, 8'h19);
    tick();
    idle();
    check("rr_pend", 32'(pend), 32'h0224);
    tick();
    check("rr_src0", 32'(out_src), 32'd2);
    check("rr_dat0", 32'(datao), 32'h12);
    tick();
    check("rr_src1", 32'(out_src), 32'd5);
    check("rr_dat1", 32'(datao), 32'h15);
    tick();
    check("rr_src2", 32'(out_src), 32'd9);
    check("rr_dat2", 32'(datao), 32'h19);
    // pointer now 10: scan 10..15 wraps to 0, reaching 2 before 9
    put(2, 8'h13);
    put(9, 8'h1E);
    tick();
    idle();
    check("rr_gap_valid", 32'(out_valid), 32'h0);
    tick();
    check("rr_wrap_src0", 32'(out_src), 32'd2);
    check("rr_wrap_dat0", 32'(datao), 32'h13);
    tick();
    check("rr_wrap_src1", 32'(out_src), 32'd9);
    check("rr_wrap_dat1", 32'(datao), 32'h1E);
    tick();
    check("rr_drain", 32'(out_valid), 32'h0);

    // backpressure, pointer at 10
    out_ready = 1'b0;
    put(3, 8'h1A);
    tick();
    idle();
    tick();
    check("bp_valid", 32'(out_valid), 32'h1);
    check("bp_datao", 32'(datao), 32'h1A);
    check("bp_src", 32'(out_src), 32'd3);
    put(3, 8'h1D);
    tick();
    idle();
    check("bp_refill_pend", 32'(pend), 32'h0008);
    check("bp_hold0", 32'(datao), 32'h1A);
    put(3, 8'h1F);
    tick();
    idle();
    check("bp_drop", 32'(drop_cnt), 32'(DROP_EXP));
    check("bp_hold1", 32'(datao), 32'h1A);
    check("bp_hold_src", 32'(out_src), 32'd3);
    tick();
    check("bp_hold2", 32'(datao), 32'h1A);
    check("bp_hold_pend", 32'(pend), 32'h0008);
    out_ready = 1'b1;
    tick();
    check("bp_next_dat", 32'(datao), 32'h1D);
    check("bp_next_pend", 32'(pend), 32'h0);
    tick();
    check("bp_drain", 32'(out_valid), 32'h0);

    // same-slot refill, pointer at 4
    put(7, 8'h17);
    tick();
    put(7, 8'h1C);
    tick();
    idle();
    check("refill_dat0", 32'(datao), 32'h17);
    check("refill_src0", 32'(out_src), 32'd7);
    check("refill_pend", 32'(pend), 32'h0080);
    tick();
    check("refill_dat1", 32'(datao), 32'h1C);
    check("refill_src1", 32'(out_src), 32'd7);
    check("refill_drop", 32'(drop_cnt), 32'(DROP_EXP));
    tick();
    check("refill_drain", 32'(out_valid), 32'h0);

    // reset mid-stream, pointer at 8
    out_ready = 1'b0;
    put(1, 8'h11);
    put(5, 8'h15);
    put(10, 8'h1A);
    put(12, 8'h1C);
    put(14, 8'h1E);
    tick();
    idle();
    tick();
    check("mid_src", 32'(out_src), 32'd10);
    check("mid_pend", 32'(pend), 32'h5022);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_datao", 32'(datao), 32'h0);
    check("mid_rst_src", 32'(out_src), 32'h0);
    check("mid_rst_pend", 32'(pend), 32'h0);
    check("mid_rst_drop", 32'(drop_cnt), 32'h0);
    out_ready = 1'b1;
    put(13, 8'h1D);
    put(6, 8'h16);
    tick();
    idle();
    tick();
    check("post_rst_src0", 32'(out_src), 32'd6);
    check("post_rst_dat0", 32'(datao), 32'h16);
    tick();
    check("post_rst_src1", 32'(out_src), 32'd13);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
